// File: rtl/dcache_miss_unit.sv
// dcache_miss_unit: load-queue miss responder (line refill + uncached I/O read).
// Optional DCMU_PERF_CNT_EN adds perf_refills_o / perf_io_o completion counters.
module dcache_miss_unit #(
  parameter int LINE_WORDS = 32,
  parameter int IO_TIMEOUT = 255
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        dc_req,
  input  logic [31:0] dc_addr,
  input  logic [1:0]  dc_op,
  output logic [31:0] dc_data,
  output logic        dc_cmp,
  output logic        bram_wr_en_o,
  output logic [10:0] bram_wr_addr_o,
  output logic [31:0] bram_wr_data_o,
  output logic        tag_wr_en_o,
  output logic        tag_wr_way_o,
  output logic [23:0] tag_wr_tag_o,
  output logic        tag_wr_vld_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [4:0]  mem_len_o,
  output logic [1:0]  mem_size_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef DCMU_PERF_CNT_EN
  ,
  output logic [31:0] perf_refills_o,
  output logic [31:0] perf_io_o
`endif
);

  localparam int LWB = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    RF_INV,
    RF_REQ,
    RF_FILL,
    RF_TAG,
    IO_REQ,
    IO_WAIT,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]    addr_q, addr_d;
  logic [1:0]     op_q, op_d;
  logic           victim_q, victim_d;
  logic [LWB-1:0] beat_q, beat_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [31:0]    data_q, data_d;

  logic last_beat;
  logic io_tmo;

  assign last_beat = (beat_q == LWB'(LINE_WORDS - 1));
  assign io_tmo    = (cnt_q == 8'(IO_TIMEOUT - 1));

  // state register
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: a granted transaction always runs to DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dc_req) begin
          state_d = dc_addr[31] ? IO_REQ : RF_INV;
        end
      end
      RF_INV: state_d = RF_REQ;
      RF_REQ: begin
        if (mem_gnt_i) begin
          state_d = RF_FILL;
        end
      end
      RF_FILL: begin
        if (mem_rvalid_i && last_beat) begin
          state_d = RF_TAG;
        end
      end
      RF_TAG: state_d = DONE;
      IO_REQ: begin
        if (mem_gnt_i) begin
          state_d = IO_WAIT;
        end
      end
      IO_WAIT: begin
        if (mem_rvalid_i || io_tmo) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // request latch, beat/timeout counters, victim way and I/O result
  always_comb begin
    addr_d   = addr_q;
    op_d     = op_q;
    victim_d = victim_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    if (state_q == IDLE && dc_req) begin
      addr_d = dc_addr;
      op_d   = dc_op;
    end
    if (state_q == RF_REQ && mem_gnt_i) begin
      beat_d = '0;
    end
    if (state_q == RF_FILL && mem_rvalid_i) begin
      beat_d = beat_q + LWB'(1);
    end
    if (state_q == RF_TAG) begin
      victim_d = ~victim_q;
    end
    if (state_q == IO_REQ && mem_gnt_i) begin
      cnt_d = '0;
    end
    if (state_q == IO_WAIT) begin
      if (mem_rvalid_i) begin
        data_d = mem_rdata_i >> {addr_q[1:0], 3'b000};
      end else if (io_tmo) begin
        data_d = 32'hFFFF_FFFF;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // datapath registers
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      addr_q   <= '0;
      op_q     <= '0;
      victim_q <= 1'b0;
      beat_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      op_q     <= op_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  // state-decoded outputs; reset suppresses every strobe at once
  always_comb begin
    dc_cmp         = 1'b0;
    bram_wr_en_o   = 1'b0;
    bram_wr_addr_o = '0;
    bram_wr_data_o = '0;
    tag_wr_en_o    = 1'b0;
    tag_wr_way_o   = 1'b0;
    tag_wr_tag_o   = '0;
    tag_wr_vld_o   = 1'b0;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    mem_len_o      = '0;
    mem_size_o     = '0;
    if (!cpu_reset_i) begin
      unique case (state_q)
        RF_INV: begin
          tag_wr_en_o  = 1'b1;
          tag_wr_way_o = victim_q;
          tag_wr_tag_o = addr_q[30:7];
        end
        RF_REQ: begin
          mem_req_o  = 1'b1;
          mem_addr_o = {addr_q[31:2+LWB], {(2 + LWB){1'b0}}};
          mem_len_o  = 5'(LINE_WORDS - 1);
          mem_size_o = 2'b10;
        end
        RF_FILL: begin
          if (mem_rvalid_i) begin
            bram_wr_en_o   = 1'b1;
            bram_wr_addr_o = {victim_q, addr_q[11:2+LWB], beat_q};
            bram_wr_data_o = mem_rdata_i;
          end
        end
        RF_TAG: begin
          tag_wr_en_o  = 1'b1;
          tag_wr_way_o = victim_q;
          tag_wr_tag_o = addr_q[30:7];
          tag_wr_vld_o = 1'b1;
        end
        IO_REQ: begin
          mem_req_o  = 1'b1;
          mem_addr_o = addr_q;
          mem_size_o = op_q;
        end
        DONE: dc_cmp = 1'b1;
        default: ;
      endcase
    end
  end

  assign dc_data = data_q;

`ifdef DCMU_PERF_CNT_EN
  logic [31:0] perf_rf_q, perf_rf_d;
  logic [31:0] perf_io_q, perf_io_d;

  // completion counters split by request type
  always_comb begin
    perf_rf_d = perf_rf_q;
    perf_io_d = perf_io_q;
    if (state_q == DONE) begin
      if (addr_q[31]) begin
        perf_io_d = perf_io_q + 32'd1;
      end else begin
        perf_rf_d = perf_rf_q + 32'd1;
      end
    end
  end

  // counter registers
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      perf_rf_q <= '0;
      perf_io_q <= '0;
    end else begin
      perf_rf_q <= perf_rf_d;
      perf_io_q <= perf_io_d;
    end
  end

  assign perf_refills_o = perf_rf_q;
  assign perf_io_o      = perf_io_q;
`endif

endmodule

// File: tb/tb_dcache_miss_unit.sv
// tb_dcache_miss_unit: directed + random transactions checked cycle by
// cycle against a per-transaction output timeline built in the bench.
`timescale 1ns/1ps
module tb_dcache_miss_unit;

  localparam int LW   = 32;
  localparam int TMO  = 255;
  localparam int NMAX = 400;

  typedef struct packed {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [1:0]  op;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
  } stim_t;

  typedef struct packed {
    logic        cmp;
    logic [31:0] data;
    logic        bwe;
    logic [10:0] ba;
    logic [31:0] bd;
    logic        twe;
    logic        tway;
    logic [23:0] ttag;
    logic        tvld;
    logic        mreq;
    logic [31:0] maddr;
    logic [4:0]  mlen;
    logic [1:0]  msz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dc_req;
  logic [31:0] dc_addr;
  logic [1:0]  dc_op;
  logic [31:0] dc_data;
  logic        dc_cmp;
  logic        bram_wr_en_o;
  logic [10:0] bram_wr_addr_o;
  logic [31:0] bram_wr_data_o;
  logic        tag_wr_en_o;
  logic        tag_wr_way_o;
  logic [23:0] tag_wr_tag_o;
  logic        tag_wr_vld_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [4:0]  mem_len_o;
  logic [1:0]  mem_size_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  dcache_miss_unit #(
    .LINE_WORDS(LW),
    .IO_TIMEOUT(TMO)
  ) dut (
    .cpu_clock_i   (clk),
    .cpu_reset_i   (rst),
    .dc_req        (dc_req),
    .dc_addr       (dc_addr),
    .dc_op         (dc_op),
    .dc_data       (dc_data),
    .dc_cmp        (dc_cmp),
    .bram_wr_en_o  (bram_wr_en_o),
    .bram_wr_addr_o(bram_wr_addr_o),
    .bram_wr_data_o(bram_wr_data_o),
    .tag_wr_en_o   (tag_wr_en_o),
    .tag_wr_way_o  (tag_wr_way_o),
    .tag_wr_tag_o  (tag_wr_tag_o),
    .tag_wr_vld_o  (tag_wr_vld_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_len_o     (mem_len_o),
    .mem_size_o    (mem_size_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  exp_t act;
  assign act = {dc_cmp, dc_data, bram_wr_en_o, bram_wr_addr_o,
                bram_wr_data_o, tag_wr_en_o, tag_wr_way_o,
                tag_wr_tag_o, tag_wr_vld_o, mem_req_o, mem_addr_o,
                mem_len_o, mem_size_o};

  int compared = 0;
  int mismatched = 0;

  stim_t st[NMAX];
  exp_t  ex[NMAX];
  int    n;
  int    done_c;
  int    fill_c;
  logic  m_victim = 1'b0;
  logic [31:0] m_data = '0;

  int          nb, ntag, ncmp, cmp_k;
  logic [10:0] first_ba, last_ba;
  logic [31:0] cmp_data;
  logic [23:0] tag0;
  logic        tvld0, tvld1, tway0, tway1;
  logic [4:0]  mlen_s;
  logic [1:0]  msz_s;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s act=%h req=%h", nm, a, e);
    end
  endtask

  task automatic clear_plan(input logic [31:0] a, input logic [1:0] op);
    for (int k = 0; k < NMAX; k++) begin
      st[k] = '0;
      st[k].addr = a;
      st[k].op = op;
      ex[k] = '0;
      ex[k].data = m_data;
    end
  endtask

  task automatic plan_idle(input int cyc);
    clear_plan(32'h0, 2'b00);
    n = cyc;
  endtask

  task automatic plan_refill(input logic [31:0] a, input int lead,
                             input int g, input bit gaps,
                             input bit idx_data, input bit strays);
    int c, b, wi;
    logic [10:0] base;
    logic [23:0] tg;
    clear_plan(a, 2'b10);
    b = lead;
    tg = 24'((a >> 7) & 32'h00FF_FFFF);
    wi = int'((a >> 2) & 32'h3FF) & ~(LW - 1);
    base = 11'((m_victim ? 1024 : 0) + wi);
    ex[b+1].twe = 1'b1;
    ex[b+1].tway = m_victim;
    ex[b+1].ttag = tg;
    for (int j = 0; j <= g; j++) begin
      ex[b+2+j].mreq = 1'b1;
      ex[b+2+j].maddr = a & ~32'(LW * 4 - 1);
      ex[b+2+j].mlen = 5'(LW - 1);
      ex[b+2+j].msz = 2'b10;
      st[b+2+j].gnt = (j == g);
    end
    c = b + 3 + g;
    fill_c = c;
    for (int i = 0; i < LW; i++) begin
      if (gaps && $urandom_range(3) == 0) c += int'($urandom_range(1, 2));
      st[c].rv = 1'b1;
      st[c].rd = idx_data ? 32'(i) : $urandom;
      ex[c].bwe = 1'b1;
      ex[c].ba = base + 11'(i);
      ex[c].bd = st[c].rd;
      c++;
    end
    ex[c].twe = 1'b1;
    ex[c].tway = m_victim;
    ex[c].ttag = tg;
    ex[c].tvld = 1'b1;
    c++;
    done_c = c;
    ex[c].cmp = 1'b1;
    n = c + 2;
    for (int k = b; k <= done_c; k++) st[k].req = 1'b1;
    if (strays) begin
      for (int k = 0; k < n; k++) begin
        if ((k < fill_c || k >= done_c - 1) && $urandom_range(3) == 0) begin
          st[k].rv = 1'b1;
          st[k].rd = $urandom;
        end
      end
    end
    m_victim = ~m_victim;
  endtask

  task automatic plan_io(input logic [31:0] a, input logic [1:0] op,
                         input int lead, input int g, input int d,
                         input logic [31:0] rdat, input bit strays);
    int b, w;
    logic [31:0] newd;
    clear_plan(a, op);
    b = lead;
    for (int j = 0; j <= g; j++) begin
      ex[b+1+j].mreq = 1'b1;
      ex[b+1+j].maddr = a;
      ex[b+1+j].msz = op;
      st[b+1+j].gnt = (j == g);
    end
    w = b + 2 + g;
    if (d >= 1 && d <= TMO) begin
      st[w+d-1].rv = 1'b1;
      st[w+d-1].rd = rdat;
      done_c = w + d;
      newd = rdat >> (8 * int'(a & 32'h3));
    end else begin
      done_c = w + TMO;
      newd = 32'hFFFF_FFFF;
    end
    ex[done_c].cmp = 1'b1;
    n = done_c + 2;
    for (int k = b; k <= done_c; k++) st[k].req = 1'b1;
    if (strays) begin
      for (int k = 0; k < n; k++) begin
        if ((k < w || k >= done_c) && $urandom_range(3) == 0) begin
          st[k].rv = 1'b1;
          st[k].rd = $urandom;
        end
      end
    end
    for (int k = done_c; k < n; k++) ex[k].data = newd;
    m_data = newd;
  endtask

  task automatic run_plan();
    nb = 0;
    ntag = 0;
    ncmp = 0;
    cmp_k = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst = st[k].rst;
      dc_req = st[k].req;
      dc_addr = st[k].addr;
      dc_op = st[k].op;
      mem_gnt_i = st[k].gnt;
      mem_rvalid_i = st[k].rv;
      mem_rdata_i = st[k].rd;
      @(negedge clk);
      compared++;
      if (act !== ex[k]) begin
        mismatched++;
        $display("FAIL outputs k=%0d act=%h req=%h", k, act, ex[k]);
      end
      if (dc_cmp) begin
        ncmp++;
        cmp_k = k;
        cmp_data = dc_data;
      end
      if (bram_wr_en_o) begin
        if (nb == 0) first_ba = bram_wr_addr_o;
        last_ba = bram_wr_addr_o;
        nb++;
      end
      if (tag_wr_en_o) begin
        if (ntag == 0) begin
          tag0 = tag_wr_tag_o;
          tvld0 = tag_wr_vld_o;
          tway0 = tag_wr_way_o;
        end else begin
          tvld1 = tag_wr_vld_o;
          tway1 = tag_wr_way_o;
        end
        ntag++;
      end
      if (mem_req_o) begin
        mlen_s = mem_len_o;
        msz_s = mem_size_o;
      end
    end
  endtask

  initial begin
    int lead, g, d, sel;
    rst = 1'b1;
    dc_req = 1'b0;
    dc_addr = '0;
    dc_op = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    repeat (3) @(posedge clk);

    plan_idle(3);
    run_plan();

    plan_refill(32'h0000_1284, 0, 0, 1'b0, 1'b1, 1'b0);
    run_plan();
    chk("rf1_latency", 32'(cmp_k - 1), 32'd35);
    chk("rf1_beats", 32'(nb), 32'd32);
    chk("rf1_first_ba", 32'(first_ba), 32'h0A0);
    chk("rf1_last_ba", 32'(last_ba), 32'h0BF);
    chk("rf1_tag", 32'(tag0), 32'h25);
    chk("rf1_tag_writes", 32'(ntag), 32'd2);
    chk("rf1_vld_seq", {30'b0, tvld0, tvld1}, 32'b01);
    chk("rf1_ways", {30'b0, tway0, tway1}, 32'b00);
    chk("rf1_cmp_pulses", 32'(ncmp), 32'd1);

    plan_refill(32'h0000_2280, 1, 2, 1'b1, 1'b0, 1'b1);
    run_plan();
    chk("rf2_first_ba", 32'(first_ba), 32'h4A0);
    chk("rf2_last_ba", 32'(last_ba), 32'h4BF);
    chk("rf2_beats", 32'(nb), 32'd32);
    chk("rf2_way", {31'b0, tway0}, 32'd1);

    plan_refill(32'h0000_3300, 0, 1, 1'b1, 1'b0, 1'b1);
    run_plan();
    chk("rf3_first_ba", 32'(first_ba), 32'h0C0);
    chk("rf3_way", {31'b0, tway0}, 32'd0);

    plan_refill(32'h0000_4100, 0, 1, 1'b0, 1'b0, 1'b0);
    n = fill_c + 10;
    st[n] = '0;
    st[n].rst = 1'b1;
    st[n].rv = 1'b1;
    st[n].rd = 32'h1234_5678;
    ex[n] = '0;
    ex[n].data = m_data;
    for (int k = n + 1; k < n + 3; k++) begin
      st[k] = '0;
      ex[k] = '0;
    end
    n = n + 3;
    m_victim = 1'b0;
    m_data = '0;
    run_plan();
    chk("rst_beats", 32'(nb), 32'd10);
    chk("rst_first_ba", 32'(first_ba), 32'h440);
    chk("rst_tag_writes", 32'(ntag), 32'd1);
    chk("rst_cmp_pulses", 32'(ncmp), 32'd0);

    plan_refill(32'h0000_5000, 0, 0, 1'b0, 1'b0, 1'b1);
    run_plan();
    chk("post_rst_way", {31'b0, tway0}, 32'd0);
    chk("post_rst_first_ba", 32'(first_ba), 32'h000);

    plan_io(32'h8000_0003, 2'b00, 0, 1, 3, 32'hAABB_CCDD, 1'b1);
    run_plan();
    chk("io_byte_data", cmp_data, 32'h0000_00AA);
    chk("io_byte_len", 32'(mlen_s), 32'd0);
    chk("io_byte_size", 32'(msz_s), 32'd0);
    chk("io_byte_pulses", 32'(ncmp), 32'd1);

    plan_io(32'h8000_0010, 2'b10, 0, 0, 0, 32'h0, 1'b0);
    run_plan();
    chk("io_tmo_data", cmp_data, 32'hFFFF_FFFF);
    chk("io_tmo_cycle", 32'(cmp_k), 32'd257);

    for (int t = 0; t < 40; t++) begin
      lead = int'($urandom_range(2));
      g = int'($urandom_range(4));
      if ($urandom_range(1) == 1) begin
        plan_refill({1'b0, 31'($urandom)}, lead, g, 1'b1, 1'b0, 1'b1);
      end else begin
        sel = int'($urandom_range(7));
        if (sel == 0) d = 0;
        else if (sel == 1) d = int'($urandom_range(250, 255));
        else d = int'($urandom_range(1, 6));
        plan_io({1'b1, 31'($urandom)}, 2'($urandom_range(2)), lead, g, d,
                $urandom, 1'b1);
      end
      run_plan();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
